// File: rtl/lut_chunk_sequencer_pkg.sv
// Shared types and helpers for the LUT chunk sequencer.
// Covers the sequencer FSM state encoding and the chunk-counter sizing helper.
package lut_chunk_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } seq_state_t;

  // A one-chunk vector still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lut_chunk_sequencer_if.sv
// Bundle of the sequencer's input-vector, LUT, and sum handshake signals.
// The slave modport is the sequencer side; the master modport is the environment side.
interface lut_chunk_sequencer_if #(
  parameter int unsigned SIZE     = 4,
  parameter int unsigned N_CHUNKS = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ACC_W    = DATA_W + $clog2(N_CHUNKS) + 1
);
  logic                       in_valid;
  logic                       in_ready;
  logic [N_CHUNKS*SIZE-1:0]   in_data;
  logic [SIZE-1:0]            lut_sel;
  logic                       lut_active;
  logic signed [DATA_W-1:0]   lut_re;
  logic signed [DATA_W-1:0]   lut_im;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [ACC_W-1:0]    out_re;
  logic signed [ACC_W-1:0]    out_im;

  modport slave (
    input  in_valid, in_data, lut_re, lut_im, out_ready,
    output in_ready, lut_sel, lut_active, out_valid, out_re, out_im
  );

  modport master (
    output in_valid, in_data, lut_re, lut_im, out_ready,
    input  in_ready, lut_sel, lut_active, out_valid, out_re, out_im
  );
endinterface

// File: rtl/lut_chunk_sequencer_acc.sv
// Complex accumulator: synchronous clear, or add a sign-extended complex term when enabled.
// Overflow from a narrowed ACC_W wraps rather than saturating.
module lut_chunk_sequencer_acc #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = DATA_W + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] add_re_i,
  input  logic signed [DATA_W-1:0] add_im_i,
  output logic signed [ACC_W-1:0]  acc_re_o,
  output logic signed [ACC_W-1:0]  acc_im_o
);

  logic signed [ACC_W-1:0] acc_re_q, acc_re_d;
  logic signed [ACC_W-1:0] acc_im_q, acc_im_d;

  always_comb begin
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    if (clr_i) begin
      acc_re_d = '0;
      acc_im_d = '0;
    end else if (en_i) begin
      // Signed size casts sign-extend the LUT terms to the accumulator width.
      acc_re_d = acc_re_q + ACC_W'(add_re_i);
      acc_im_d = acc_im_q + ACC_W'(add_im_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_re_q <= '0;
      acc_im_q <= '0;
    end else begin
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
    end
  end

  assign acc_re_o = acc_re_q;
  assign acc_im_o = acc_im_q;

endmodule

// File: rtl/lut_chunk_sequencer.sv
// Time-multiplexes one external LUT across N_CHUNKS select chunks of a control vector.
// Accumulates the complex LUT results and presents the sum on a valid/ready output.
module lut_chunk_sequencer
  import lut_chunk_sequencer_pkg::*;
#(
  parameter int unsigned SIZE     = 4,
  parameter int unsigned N_CHUNKS = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ACC_W    = DATA_W + $clog2(N_CHUNKS) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lut_chunk_sequencer_if.slave  bus_io
);

  localparam int unsigned VecW = N_CHUNKS * SIZE;
  localparam int unsigned CntW = cnt_width(N_CHUNKS);
  localparam logic [CntW-1:0] LastCnt = CntW'(N_CHUNKS - 1);

  seq_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [VecW-1:0] data_q, data_d;
  logic            acc_clr;
  logic            acc_en;
  logic            in_ready;
  logic            accept;
  logic [SIZE-1:0] chunk_sel;

  assign in_ready = (state_q == StIdle) || ((state_q == StDone) && bus_io.out_ready);
  assign accept   = bus_io.in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    unique case (state_q)
      StIdle: ;
      StRun: begin
        acc_en = 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (bus_io.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Loading from IDLE or straight out of DONE; the latter avoids an IDLE bubble.
    if (accept) begin
      state_d = StRun;
      cnt_d   = '0;
      data_d  = bus_io.in_data;
      acc_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign chunk_sel = data_q[32'(cnt_q) * SIZE +: SIZE];

  lut_chunk_sequencer_acc #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (acc_clr),
    .en_i     (acc_en),
    .add_re_i (bus_io.lut_re),
    .add_im_i (bus_io.lut_im),
    .acc_re_o (bus_io.out_re),
    .acc_im_o (bus_io.out_im)
  );

  assign bus_io.in_ready   = in_ready;
  assign bus_io.lut_active = (state_q == StRun);
  assign bus_io.lut_sel    = (state_q == StRun) ? chunk_sel : '0;
  assign bus_io.out_valid  = (state_q == StDone);

endmodule

// File: tb/tb_lut_chunk_sequencer.sv
// Directed bench for lut_chunk_sequencer across three parameter sets with behavioural LUTs.
// Inputs change on the falling edge and outputs are sampled 1 ns later.
module tb_lut_chunk_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_a_n;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  // A: SIZE=2, N_CHUNKS=3, LUT re=sel, im=-sel.
  lut_chunk_sequencer_if #(.SIZE(2), .N_CHUNKS(3), .DATA_W(16), .ACC_W(19)) ifa ();
  // B: single chunk, SIZE=4, LUT re=7 at sel=F else sel, im=-sel.
  lut_chunk_sequencer_if #(.SIZE(4), .N_CHUNKS(1), .DATA_W(16), .ACC_W(17)) ifb ();
  // C: DATA_W=8 full scale, LUT returns -128 for everything.
  lut_chunk_sequencer_if #(.SIZE(2), .N_CHUNKS(3), .DATA_W(8), .ACC_W(11)) ifc ();

  assign ifa.lut_re = 16'(ifa.lut_sel);
  assign ifa.lut_im = -16'(ifa.lut_sel);
  assign ifb.lut_re = (ifb.lut_sel == 4'hF) ? 16'd7 : 16'(ifb.lut_sel);
  assign ifb.lut_im = -16'(ifb.lut_sel);
  assign ifc.lut_re = 8'h80;
  assign ifc.lut_im = 8'h80;

  lut_chunk_sequencer #(.SIZE(2), .N_CHUNKS(3), .DATA_W(16), .ACC_W(19)) u_dut_a (
    .clk    (clk),
    .rst_n  (rst_a_n),
    .bus_io (ifa)
  );

  lut_chunk_sequencer #(.SIZE(4), .N_CHUNKS(1), .DATA_W(16), .ACC_W(17)) u_dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (ifb)
  );

  lut_chunk_sequencer #(.SIZE(2), .N_CHUNKS(3), .DATA_W(8), .ACC_W(11)) u_dut_c (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (ifc)
  );

  task automatic check_eq(input string tag, input logic signed [63:0] obs,
                          input logic signed [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rst_a_n = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b0;
    ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.out_ready = 1'b0;

    #12;
    check_eq("rst_in_ready", ifa.in_ready, 1);
    check_eq("rst_out_valid", ifa.out_valid, 0);
    check_eq("rst_lut_active", ifa.lut_active, 0);
    check_eq("rst_lut_sel", ifa.lut_sel, 0);
    check_eq("rst_out_re", ifa.out_re, 0);
    check_eq("rst_out_im", ifa.out_im, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rst_a_n = 1'b1;

    // Basic sum 11_10_01 -> selects 1,2,3 -> 6/-6.
    @(negedge clk);
    ifa.in_valid = 1'b1; ifa.in_data = 6'b11_10_01;
    #1 check_eq("basic_in_ready_idle", ifa.in_ready, 1);
    @(negedge clk);
    ifa.in_valid = 1'b0;
    #1 check_eq("basic_active", ifa.lut_active, 1);
    check_eq("basic_sel0", ifa.lut_sel, 1);
    check_eq("basic_in_ready_run", ifa.in_ready, 0);
    @(negedge clk);
    #1 check_eq("basic_sel1", ifa.lut_sel, 2);
    check_eq("basic_no_valid_early", ifa.out_valid, 0);
    @(negedge clk);
    #1 check_eq("basic_sel2", ifa.lut_sel, 3);
    @(negedge clk);
    #1 check_eq("basic_out_valid", ifa.out_valid, 1);
    check_eq("basic_out_re", ifa.out_re, 6);
    check_eq("basic_out_im", ifa.out_im, -6);
    check_eq("basic_done_sel", ifa.lut_sel, 0);
    check_eq("basic_done_active", ifa.lut_active, 0);

    // Backpressure: hold DONE with out_ready low.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 check_eq("bp_out_valid", ifa.out_valid, 1);
      check_eq("bp_out_re", ifa.out_re, 6);
      check_eq("bp_out_im", ifa.out_im, -6);
      check_eq("bp_in_ready", ifa.in_ready, 0);
    end
    @(negedge clk);
    ifa.out_ready = 1'b1;
    #1 check_eq("bp_release_in_ready", ifa.in_ready, 1);
    @(negedge clk);
    #1 check_eq("bp_idle_valid", ifa.out_valid, 0);
    check_eq("bp_idle_in_ready", ifa.in_ready, 1);

    // Back-to-back: 01_01_01 then 11_11_11, second offered during RUN (must be ignored).
    ifa.in_valid = 1'b1; ifa.in_data = 6'b01_01_01;
    @(negedge clk);
    ifa.in_data = 6'b11_11_11;
    #1 check_eq("b2b_first_sel0", ifa.lut_sel, 1);
    check_eq("b2b_in_ready_run", ifa.in_ready, 0);
    @(negedge clk);
    #1 check_eq("b2b_first_sel1", ifa.lut_sel, 1);
    @(negedge clk);
    #1 check_eq("b2b_first_sel2", ifa.lut_sel, 1);
    @(negedge clk);
    #1 check_eq("b2b_first_valid", ifa.out_valid, 1);
    check_eq("b2b_first_re", ifa.out_re, 3);
    check_eq("b2b_first_im", ifa.out_im, -3);
    check_eq("b2b_done_in_ready", ifa.in_ready, 1);
    @(negedge clk);
    ifa.in_valid = 1'b0;
    #1 check_eq("b2b_second_active", ifa.lut_active, 1);
    check_eq("b2b_second_sel0", ifa.lut_sel, 3);
    check_eq("b2b_second_no_valid", ifa.out_valid, 0);
    @(negedge clk);
    #1 check_eq("b2b_second_sel1", ifa.lut_sel, 3);
    @(negedge clk);
    #1 check_eq("b2b_second_sel2", ifa.lut_sel, 3);
    @(negedge clk);
    #1 check_eq("b2b_second_valid", ifa.out_valid, 1);
    check_eq("b2b_second_re", ifa.out_re, 9);
    check_eq("b2b_second_im", ifa.out_im, -9);
    @(negedge clk);
    #1 check_eq("b2b_back_idle", ifa.out_valid, 0);

    // Reset mid-RUN after two chunks.
    ifa.in_valid = 1'b1; ifa.in_data = 6'b11_10_01;
    @(negedge clk);
    ifa.in_valid = 1'b0;
    #1 check_eq("mid_sel0", ifa.lut_sel, 1);
    @(negedge clk);
    #1 check_eq("mid_sel1", ifa.lut_sel, 2);
    @(negedge clk);
    rst_a_n = 1'b0;
    #1 check_eq("mid_rst_active", ifa.lut_active, 0);
    check_eq("mid_rst_sel", ifa.lut_sel, 0);
    check_eq("mid_rst_valid", ifa.out_valid, 0);
    check_eq("mid_rst_re", ifa.out_re, 0);
    check_eq("mid_rst_im", ifa.out_im, 0);
    @(negedge clk);
    rst_a_n = 1'b1;
    @(negedge clk);
    #1 check_eq("mid_post_rst_valid", ifa.out_valid, 0);
    check_eq("mid_post_rst_in_ready", ifa.in_ready, 1);
    ifa.in_valid = 1'b1; ifa.in_data = 6'b00_00_10;
    @(negedge clk);
    ifa.in_valid = 1'b0;
    #1 check_eq("mid_new_sel0", ifa.lut_sel, 2);
    @(negedge clk);
    @(negedge clk);
    #1 check_eq("mid_new_sel2", ifa.lut_sel, 0);
    @(negedge clk);
    #1 check_eq("mid_new_valid", ifa.out_valid, 1);
    check_eq("mid_new_re", ifa.out_re, 2);
    check_eq("mid_new_im", ifa.out_im, -2);

    // N_CHUNKS=1: RUN lasts one cycle.
    @(negedge clk);
    ifb.in_valid = 1'b1; ifb.in_data = 4'hF;
    @(negedge clk);
    ifb.in_valid = 1'b0;
    #1 check_eq("one_active", ifb.lut_active, 1);
    check_eq("one_sel", ifb.lut_sel, 15);
    check_eq("one_no_valid", ifb.out_valid, 0);
    @(negedge clk);
    #1 check_eq("one_valid", ifb.out_valid, 1);
    check_eq("one_re", ifb.out_re, 7);
    check_eq("one_im", ifb.out_im, -15);
    ifb.out_ready = 1'b1;
    @(negedge clk);
    #1 check_eq("one_idle", ifb.out_valid, 0);

    // Full-scale: three -128 terms must reach -384 without wrapping.
    ifc.in_valid = 1'b1; ifc.in_data = 6'b10_01_11;
    @(negedge clk);
    ifc.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1 check_eq("fs_valid", ifc.out_valid, 1);
    check_eq("fs_re", ifc.out_re, -384);
    check_eq("fs_im", ifc.out_im, -384);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lut_chunk_sequencer.md
Name: lut_chunk_sequencer

Overview:
- Time-multiplexes one combinational LUT (`size`-bit select, complex partial-sum result) across a wide control-bit vector.
- Accepts one `N_CHUNKS*SIZE`-bit control vector per transaction and drives one `SIZE`-bit chunk per cycle as the LUT select.
- Accumulates the returned complex values and presents the complex sum on a valid/ready output.
- Sits between the control-bit front end and the filter output adder, replacing N parallel LUT instances.

Parameters:
- SIZE, 4, LUT select width in bits per chunk.
- N_CHUNKS, 4, chunks per input vector; must be ≥1.
- DATA_W, 16, signed width of the LUT result real/imag fields.
- ACC_W, DATA_W+$clog2(N_CHUNKS)+1, signed accumulator and output field width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  sequencer can accept a vector this cycle.
- in_data  in  N_CHUNKS*SIZE  control vector; chunk k is in_data[k*SIZE +: SIZE].
- lut_sel  out  SIZE  select driven to the LUT.
- lut_active  out  1  high while lut_sel is meaningful.
- lut_re  in  DATA_W  signed LUT real result, combinational from lut_sel.
- lut_im  in  DATA_W  signed LUT imag result, combinational from lut_sel.
- out_valid  out  1  sum valid.
- out_ready  in  1  downstream accepts sum.
- out_re  out  ACC_W  signed accumulated real part.
- out_im  out  ACC_W  signed accumulated imag part.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; chunk counter=0; data register=0; acc_re=acc_im=0.
  - in_ready=1 once reset deasserts; out_valid=0; lut_active=0; lut_sel=0; out_re=out_im=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: register in_data, cnt←0, acc←0, →RUN.
- RUN:
  - lut_active=1; lut_sel = data_reg chunk[cnt] (combinational from registered state); in_ready=0.
  - Each edge: acc ← acc + sign-extended lut result.
  - cnt<N_CHUNKS-1: cnt++.
  - cnt==N_CHUNKS-1: →DONE.
- DONE:
  - out_valid=1; out_re/out_im=acc, held stable while out_ready=0.
  - in_ready=out_ready.
  - out_ready & in_valid: load the new vector, reset acc/cnt, →RUN. This is the back-to-back path with no IDLE bubble.
  - out_ready & !in_valid: →IDLE.
- Latency: input accepted at edge E → out_valid high after edge E+N_CHUNKS.
- Throughput: one vector per N_CHUNKS+1 cycles max.
- Chunk order: chunk 0 (LSBs) first.
- Arithmetic: two's complement; ACC_W sized so N_CHUNKS full-scale sums cannot overflow. Any overflow from a user-narrowed ACC_W wraps and is not saturated.
- lut_sel=0 and lut_active=0 outside RUN; lut results are ignored outside RUN.
- N_CHUNKS=1: RUN lasts exactly one cycle.
- Reset mid-RUN or mid-DONE: immediate return to reset values; the partial sum is discarded and no out_valid is produced.
- in_valid in RUN: ignored (in_ready=0). The source must hold the vector, per the valid/ready rule.

Decomposition:
- Shared package filter_pkg:
  - complex typedef (signed re/im).
  - seq_state_t enum {IDLE,RUN,DONE}.
  - function chunk_of(data,k).
- Natural sub-module: complex_accumulator (clear, enable, add, ACC_W registers).
- The LUT itself is instantiated outside; the bench uses a behavioural LUT model.

Test Plan:
- Use SIZE=2, N_CHUNKS=3, with LUT model re=sel, im=-sel.
- Basic sum: in_data=6'b11_10_01 → lut_sel 1,2,3 on consecutive cycles → out_re=6, out_im=-6, out_valid 3 edges after accept.
- Backpressure: out_ready=0 for 5 cycles in DONE → out_valid and value held, in_ready=0; release → IDLE next edge.
- Back-to-back: two vectors 6'b01_01_01 then 6'b11_11_11 with out_ready=1 → sums 3 then 9, second lut_sel sequence starts the edge after the first handshake.
- Reset mid-RUN: assert rst_n=0 after 2nd chunk → outputs at reset values immediately; next vector 6'b00_00_10 yields 2/-2.
- Edge case: N_CHUNKS=1, SIZE=4, LUT re=7 for sel=4'hF → out_re=7, out_im=-15 one edge after accept.
- Full-scale: DATA_W=8, LUT returns -128 for all → out_re=-384, no wrap.
